// File: rtl/instruction_cache_if.sv
// CPU fetch port and block-memory port of the instruction cache, bundled.
// master: the CPU/memory environment; slave: the cache.
interface instruction_cache_if;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    output pc,
    output mem_readdata,
    output mem_busywait,
    input  instruction,
    input  busywait,
    input  mem_read,
    input  mem_address
  );

  modport slave (
    input  pc,
    input  mem_readdata,
    input  mem_busywait,
    output instruction,
    output busywait,
    output mem_read,
    output mem_address
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 blocks x 4 words, 1 KiB space.
// Hits answer combinationally; misses stall via busywait while a block refills.
module instruction_cache (
  input  logic               clk,
  input  logic               reset,
  instruction_cache_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_next_s;

  logic [7:0]   valid_r;
  logic [2:0]   tag_r  [8];
  logic [127:0] data_r [8];

  logic [2:0]   idx_s;
  logic [2:0]   tag_s;
  logic [1:0]   off_s;
  logic         hit_s;
  logic         capture_s;
  logic         unused_s;

  function automatic logic [31:0] select_word(input logic [127:0] blk, input logic [1:0] off);
    logic [31:0] word;
    case (off)
      2'd0:    word = blk[31:0];
      2'd1:    word = blk[63:32];
      2'd2:    word = blk[95:64];
      2'd3:    word = blk[127:96];
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign idx_s    = bus.pc[6:4];
  assign tag_s    = bus.pc[9:7];
  assign off_s    = bus.pc[3:2];
  assign hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  // Upper PC bits alias and byte-offset bits are ignored by design.
  assign unused_s = ^{bus.pc[31:10], bus.pc[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and handshake outputs; reset forces the bus quiet and abandons a fill.
  always_comb begin
    state_next_s    = state_r;
    bus.busywait    = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_address = 6'd0;
    capture_s       = 1'b0;
    case (state_r)
      IDLE: begin
        bus.busywait = !hit_s;
        if (!hit_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        bus.busywait    = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.pc[9:4];
        if (!bus.mem_busywait) begin
          capture_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = FETCH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    if (reset) begin
      bus.busywait = 1'b0;
      bus.mem_read = 1'b0;
      capture_s    = 1'b0;
      state_next_s = IDLE;
    end else begin
      capture_s = capture_s;
    end
  end

  // Tag/valid/data arrays: cleared on reset, written only on the capture edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_r[i]  <= 3'd0;
        data_r[i] <= 128'd0;
      end
    end else if (capture_s) begin
      valid_r[idx_s] <= 1'b1;
      tag_r[idx_s]   <= tag_s;
      data_r[idx_s]  <= bus.mem_readdata;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Word select from the indexed line.
  always_comb begin
    bus.instruction = select_word(data_r[idx_s], off_s);
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the CPU's PC/INSTRUCTION port and the slow block-organised instruction memory. Hits return the addressed 32-bit instruction in the same cycle with BUSYWAIT low. Misses stall the CPU via BUSYWAIT while a 16-byte block is fetched from memory, then resume. The CPU gates its PC update with BUSYWAIT and holds PC stable while it is high.

## Interface
- No parameters. Geometry is fixed: 8 blocks × 4 words (16 B), 1 KiB address space.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset, sampled on posedge CLK.
- PC  in  32  CPU fetch address.
  - PC[1:0] ignored; PC[3:2] = word offset; PC[6:4] = index; PC[9:7] = tag; PC[31:10] ignored (aliases).
- INSTRUCTION  out  32  word PC[3:2] of the block at index PC[6:4]; combinational; meaningful only when BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to CPU; combinational.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address = PC[9:4].
- MEM_READDATA  in  128  fetched block; word w occupies bits [32w+31:32w].
- MEM_BUSYWAIT  in  1  memory busy; data valid in a FETCH cycle where it is low.

## Operation
- Storage per index: valid bit, 3-bit tag, 128-bit data block.
- hit = valid[idx] && (tag[idx] == PC[9:7]).
- FSM states: IDLE, FETCH.
- IDLE
  - BUSYWAIT = !hit. MEM_READ = 0. MEM_ADDRESS = 0.
  - On miss, next state is FETCH.
- FETCH
  - BUSYWAIT = 1. MEM_READ = 1. MEM_ADDRESS = PC[9:4].
  - While MEM_BUSYWAIT = 1, stay in FETCH.
  - When MEM_BUSYWAIT = 0 at a posedge: write MEM_READDATA into data[idx], write tag[idx] = PC[9:7], set valid[idx] = 1, and go to IDLE. The next IDLE cycle is a hit.
- Memory contract: the memory raises MEM_BUSYWAIT in the same cycle it first sees MEM_READ=1. The cache never samples MEM_READDATA in a cycle where MEM_BUSYWAIT=1.
- No writes from the CPU. No prefetch. No replacement choice: direct-mapped overwrite.
- A refill overwrites any valid block at that index (conflict eviction).

## Timing
- Reset (RESET=1 at posedge): state to IDLE; all valid bits, tags and data arrays cleared to 0.
  - While RESET is high, BUSYWAIT = 0 and MEM_READ = 0 regardless of state or hit.
  - INSTRUCTION reads 32'h0 after reset until the first fill.
- Reset during FETCH: the fetch is abandoned and no array is written. MEM_READ drops in the first cycle RESET is high; the memory must tolerate the abort.
- Hit latency: 0 cycles. INSTRUCTION is valid combinationally within the cycle PC is presented.
- Miss latency, with the memory holding MEM_BUSYWAIT high for L cycles and then low for one cycle:
  - 1 IDLE-miss cycle + (L+1) FETCH cycles.
  - BUSYWAIT is high for L+2 consecutive cycles and falls in the cycle after the capture edge.
- A PC change during FETCH is a CPU protocol violation. Behaviour is undefined; the bench must not do it.
- MEM_READ deasserts in the cycle after the capture edge; there is no back-to-back request in the capture cycle.

## Test plan
- Cold miss: RESET for 2 cycles, then PC=0x000, memory L=5 returning block {W3,W2,W1,W0} = {0x03000000,0x02000000,0x01000000,0x00000000}.
  - Required: MEM_READ=1 with MEM_ADDRESS=0 for 6 cycles; BUSYWAIT high exactly 7 cycles; then INSTRUCTION=0x00000000 with BUSYWAIT=0.
- Spatial hits: after the cold fill, PC=0x004, 0x008, 0x00C on successive cycles.
  - Required: BUSYWAIT=0 throughout, MEM_READ never asserted, INSTRUCTION = 0x01000000, 0x02000000, 0x03000000.
- Conflict eviction: fill index 0 from PC=0x000, then fetch PC=0x080 (tag 1, MEM_ADDRESS=0x08), then PC=0x000 again.
  - Required: the second and third accesses both miss and refetch; each hit afterwards returns the correct block's words.
- Index independence and aliasing: fill PC=0x010 (index 1) and PC=0x000, then revisit both.
  - Required: no misses on revisit. PC=0x400 hits and returns the same word as PC=0x000.
- Reset mid-fetch: miss on PC=0x020, assert RESET during the 3rd FETCH cycle.
  - Required: MEM_READ=0 and BUSYWAIT=0 in that cycle; after release, PC=0x020 misses again (valid[2]=0) and a full fetch occurs.
- Zero-latency memory (L=0): miss on PC=0x030.
  - Required: BUSYWAIT high exactly 2 cycles; correct word on the 3rd cycle.
